// File: rtl/sja_bus_pkg.sv
// Shared definitions for the SJA1000-style Intel-mode multiplexed bus.
// Used by the bus responder and by the initiator that drives it.
package sja_bus_pkg;

  localparam int AD_W = 8;

  localparam logic [AD_W-1:0] REG_MODE   = 8'h00;
  localparam logic [AD_W-1:0] REG_CMD    = 8'h01;
  localparam logic [AD_W-1:0] REG_STATUS = 8'h02;
  localparam logic [AD_W-1:0] REG_IR     = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SEL,
    ST_WR_ACT,
    ST_RD_ACT,
    ST_DONE
  } bus_state_e;

endpackage

// File: rtl/sja_sync2.sv
// Parameterized-width two-flop synchronizer with a per-bit reset value,
// so idle-high strobes do not look asserted coming out of reset.
module sja_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sja_bus_responder.sv
// Device end of the SJA1000 Intel-mode bus: latches the address on ALE,
// commits writes into a small register file and drives prefetched read data.
module sja_bus_responder
  import sja_bus_pkg::*;
#(
  parameter int              NREG       = 32,
  parameter logic [AD_W-1:0] RD_DEFAULT = 8'hFF,
  localparam int             IDX_W      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [AD_W-1:0]  SJ_AD,
  input  logic             SJ_ALE,
  input  logic             SJ_CS_n,
  input  logic             SJ_RD_n,
  input  logic             SJ_WR_n,
  output logic             wr_strobe,
  output logic [AD_W-1:0]  wr_addr,
  output logic [AD_W-1:0]  wr_data,
  output logic             rd_strobe,
  input  logic [IDX_W-1:0] host_addr,
  input  logic             host_we,
  input  logic [AD_W-1:0]  host_wdata,
  output logic [AD_W-1:0]  host_rdata,
  output logic             proto_err,
  input  logic             err_clr
);

  logic [3:0]      ctl_s;
  logic [AD_W-1:0] ad_s;
  logic            ale_s, cs_n_s, rd_n_s, wr_n_s;

  sja_sync2 #(.W(4), .RST_VAL(4'b0111)) u_sync_ctl (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  ({SJ_ALE, SJ_CS_n, SJ_RD_n, SJ_WR_n}),
    .q_o  (ctl_s)
  );

  sja_sync2 #(.W(AD_W), .RST_VAL('0)) u_sync_ad (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (SJ_AD),
    .q_o  (ad_s)
  );

  assign {ale_s, cs_n_s, rd_n_s, wr_n_s} = ctl_s;

  bus_state_e      state_q;
  logic [AD_W-1:0] addr_q;
  logic            addr_valid_q;
  logic            prefetch_q;
  logic [AD_W-1:0] rd_q;
  logic            ale_prev_q, rd_n_prev_q, wr_n_prev_q;
  logic [AD_W-1:0] regfile_q [NREG];

  logic ale_fall, ale_rise, rd_rise, wr_rise;
  logic abort, commit_wr, proto_set, addr_in_range, oe;
  logic [IDX_W-1:0] addr_idx;

  assign ale_fall = ~ale_s & ale_prev_q;
  assign ale_rise = ale_s & ~ale_prev_q;
  assign rd_rise  = rd_n_s & ~rd_n_prev_q;
  assign wr_rise  = wr_n_s & ~wr_n_prev_q;

  assign abort = ale_rise &&
                 (state_q == ST_SEL || state_q == ST_WR_ACT || state_q == ST_RD_ACT);
  assign commit_wr = (state_q == ST_WR_ACT) && wr_rise && !abort;
  assign proto_set = (~rd_n_s & ~wr_n_s) | (~cs_n_s & (state_q == ST_IDLE)) | abort;

  assign addr_in_range = ({1'b0, addr_q} < 9'(NREG));
  assign addr_idx      = addr_q[IDX_W-1:0];

  // Output enable follows the raw pins so read data needs no synchronizer delay.
  assign oe    = rst_n & addr_valid_q & ~SJ_CS_n & ~SJ_RD_n;
  assign SJ_AD = oe ? rd_q : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      prefetch_q   <= 1'b0;
      wr_strobe    <= 1'b0;
      rd_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      proto_err    <= 1'b0;
      ale_prev_q   <= 1'b0;
      rd_n_prev_q  <= 1'b1;
      wr_n_prev_q  <= 1'b1;
    end else begin
      ale_prev_q  <= ale_s;
      rd_n_prev_q <= rd_n_s;
      wr_n_prev_q <= wr_n_s;
      wr_strobe   <= 1'b0;
      rd_strobe   <= 1'b0;
      prefetch_q  <= 1'b0;
      proto_err   <= proto_set | (proto_err & ~err_clr);

      if (abort) begin
        state_q      <= ST_IDLE;
        addr_valid_q <= 1'b0;
      end else begin
        case (state_q)
          // A second ALE pulse before chip select simply re-latches the address.
          ST_IDLE, ST_ADDR: begin
            if (ale_fall) begin
              addr_q       <= ad_s;
              addr_valid_q <= 1'b1;
              prefetch_q   <= 1'b1;
              state_q      <= ST_ADDR;
            end else if (state_q == ST_ADDR && !cs_n_s) begin
              state_q <= ST_SEL;
            end
          end
          ST_SEL: begin
            if (!wr_n_s)      state_q <= ST_WR_ACT;
            else if (!rd_n_s) state_q <= ST_RD_ACT;
          end
          ST_WR_ACT: begin
            if (wr_rise) begin
              state_q   <= ST_DONE;
              wr_strobe <= 1'b1;
              wr_addr   <= addr_q;
              wr_data   <= ad_s;
            end
          end
          ST_RD_ACT: begin
            if (rd_rise) begin
              state_q   <= ST_DONE;
              rd_strobe <= 1'b1;
            end
          end
          ST_DONE: begin
            if (cs_n_s) begin
              state_q      <= ST_IDLE;
              addr_valid_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // The bus write is issued last so it wins a same-address collision with the host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regfile_q[i] <= '0;
      host_rdata <= '0;
      rd_q       <= '0;
    end else begin
      if (host_we)                   regfile_q[host_addr] <= host_wdata;
      if (commit_wr && addr_in_range) regfile_q[addr_idx]  <= ad_s;
      host_rdata <= regfile_q[host_addr];
      if (prefetch_q) rd_q <= addr_in_range ? regfile_q[addr_idx] : RD_DEFAULT;
    end
  end

endmodule

// File: doc/sja_bus_responder.md
# sja_bus_responder

Synthesizable responder for the SJA1000-style Intel-mode multiplexed bus: ALE, CS_n, RD_n, WR_n and the 8-bit AD bus. It is the device end of the bus our CAN-controller write/read initiator drives. The block latches the address on ALE, commits write cycles into a small register file and drives read data onto AD. It serves as an in-FPGA SJA1000 stand-in for loopback bring-up and as the bus-slave core for board-to-board register access.

## Interface
- NREG, 32: implemented registers at addresses 0..NREG-1; must be a power of two, ≤256.
- RD_DEFAULT, 8'hFF: value returned for reads of addresses ≥ NREG.
- clk  in  1  responder clock; frequency ≥ 4× the initiator's clock.
- rst_n  in  1  reset, asynchronous, active-low.
- SJ_AD  inout  8  multiplexed address/data; driven only during a valid read, hi-Z otherwise.
- SJ_ALE  in  1  address latch enable, active-high.
- SJ_CS_n / SJ_RD_n / SJ_WR_n  in  1 each  chip select, read strobe, write strobe (all active-low).
- wr_strobe  out  1  one-cycle pulse per committed bus write.
- wr_addr  out  8  address of the last bus write; held.
- wr_data  out  8  data of the last bus write; held.
- rd_strobe  out  1  one-cycle pulse per completed bus read.
- host_addr  in  log2(NREG)  local-side register select.
- host_we  in  1  local-side write enable.
- host_wdata  in  8  local-side write data.
- host_rdata  out  8  regfile[host_addr], registered, 1-cycle latency.
- proto_err  out  1  sticky protocol-error flag.
- err_clr  in  1  clears proto_err; a new error in the same cycle wins.

## Operation
- The ALE, CS_n, RD_n, WR_n and AD inputs each pass through a 2-flop synchronizer. Edge detection uses the synced copies.
- FSM states: IDLE, ADDR, SEL, WR_ACT, RD_ACT, DONE.
  - IDLE → ADDR on a synced ALE falling edge. Latch addr_q = synced AD and set addr_valid.
  - ADDR → SEL on synced CS_n low.
  - SEL → WR_ACT on synced WR_n low; SEL → RD_ACT on synced RD_n low.
  - WR_ACT → DONE on a synced WR_n rising edge. Commit: if addr_q < NREG, regfile[addr_q] = synced AD. Set wr_addr and wr_data, pulse wr_strobe.
  - RD_ACT → DONE on a synced RD_n rising edge; pulse rd_strobe.
  - DONE → IDLE on synced CS_n high; clear addr_valid.
- Read data is prefetched: rd_q = regfile[addr_q], or RD_DEFAULT for addr_q ≥ NREG, loaded one cycle after the ALE fall.
- SJ_AD output enable is combinational from the raw pins: oe = rst_n & addr_valid & ~SJ_CS_n & ~SJ_RD_n. Driven value is rd_q. This gives zero synchronizer latency on read data.
- proto_err is set on any of the following:
  - synced RD_n and WR_n both low;
  - synced CS_n low while in IDLE;
  - synced ALE rising while in SEL, WR_ACT or RD_ACT. The FSM aborts to IDLE, clears addr_valid and commits nothing.
- A bus commit and host_we to the same address in the same cycle: the bus write wins. Otherwise both proceed.
- A host write to addr_q between the ALE fall and the read does not update rd_q. The bus returns the prefetched value.

## Timing
- Reset values:
  - wr_strobe, rd_strobe, proto_err = 0;
  - wr_addr, wr_data, host_rdata, rd_q, addr_q = 0;
  - all regfile entries = 0; addr_valid = 0; FSM = IDLE.
  - SJ_AD is hi-Z immediately on rst_n low, because oe is gated by rst_n asynchronously.
- Write commit occurs 3 clk after the raw WR_n rising edge (2 sync + 1 edge-detect/commit). wr_strobe is high that cycle; the regfile is updated on the same edge.
- Read data is valid on AD within pad delay of RD_n falling, provided the ALE fall was ≥ 4 clk earlier. The initiator's 2-cycle ALE-low-to-RD gap guarantees this at the ≥ 4× clock ratio.
- rd_strobe fires 3 clk after the raw RD_n rising edge.
- Reset mid-transaction: the FSM returns to IDLE and no partial commit occurs. The next transaction requires a fresh ALE.

## Structure
- Package sja_bus_pkg holds:
  - the FSM state enum;
  - AD_W = 8;
  - the SJA1000 register address constants (MODE = 0x00, CMD = 0x01, STATUS = 0x02, IR = 0x03), shared with the initiator.
- Sub-module sja_sync2: parameterized-width 2-flop synchronizer, instantiated for the strobes and the AD bus.

## Test plan
- Write 0xA5 to address 0x04 via the initiator model → wr_strobe pulses once; wr_addr = 0x04, wr_data = 0xA5; host_rdata = 0xA5 at host_addr 4.
- Preload reg 0x07 = 0x3C via host_we, then bus-read 0x07 → AD = 0x3C while RD_n is low; hi-Z before and after; rd_strobe pulses once.
- Bus read of address 0x40 (≥ NREG) → AD = 0xFF; a bus write to 0x40 leaves all regfile entries unchanged.
- Drive RD_n and WR_n low together → proto_err = 1 and stays 1 after the cycle ends; err_clr → 0.
- Assert rst_n low while RD_n is low mid-read → AD immediately hi-Z; all outputs at reset values; the following write of 0x11 to 0x02 commits correctly.
- Same-cycle bus commit of 0x55 and host write of 0xAA to address 3 → reg 3 = 0x55.
